// File: rtl/dmem_responder.sv
// dmem_responder: target-side data memory for the core's memory stage.
// The RAM holds DEPTH 32-bit words. A request is accepted only when the
// block is idle. After WAIT_CYCLES wait states the access executes: either a
// byte-enabled store, or a full-word load, or an error for a misaligned or
// out-of-range address. The result is then presented on the response channel.
// Only one transaction can be in flight at a time.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   req_valid  request present          req_ready  idle, can accept a request
//   req_we     1 = store, 0 = load      req_addr   byte address
//   req_wdata  store data               req_be     store byte enables
//   rsp_valid  response present         rsp_ready  initiator takes the response
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    misaligned or out-of-range request
//
// state  | meaning
// S_IDLE | waiting for a request; req_ready high
// S_WAIT | wait states counting down; request fields latched
// S_RESP | access done; response held until rsp_ready

module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          accept;
    logic          exec_go;
    logic          ex_we;
    logic [31:0]   ex_addr;
    logic [31:0]   ex_wdata;
    logic [3:0]    ex_be;
    logic          ex_err;
    logic [AW-1:0] ex_idx;

    // The RAM is not touched by reset; it starts at zero.
    logic [31:0]   mem_q [DEPTH] = '{default: '0};

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With no wait states the access executes on the accept edge itself,
    // before the request fields have been latched, so take them straight
    // from the request port while idle.
    always_comb begin
        if (state_q == S_IDLE) begin
            ex_we    = req_we;
            ex_addr  = req_addr;
            ex_wdata = req_wdata;
            ex_be    = req_be;
        end else begin
            ex_we    = we_q;
            ex_addr  = addr_q;
            ex_wdata = wdata_q;
            ex_be    = be_q;
        end
    end

    assign ex_idx = ex_addr[AW+1:2];
    assign ex_err = (ex_addr[1:0] != 2'b00) || (ex_addr[31:2] >= 30'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        exec_go = 1'b1;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    exec_go = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (exec_go) begin
            err_d   = ex_err;
            rdata_d = (ex_err || ex_we) ? 32'h0 : mem_q[ex_idx];
        end else if ((state_q == S_RESP) && rsp_ready) begin
            err_d   = 1'b0;
            rdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // The RAM has no reset port, so the write is qualified with rst here to
    // keep a store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (rst && exec_go && ex_we && !ex_err) begin
            for (int i = 0; i < 4; i++) begin
                if (ex_be[i]) begin
                    mem_q[ex_idx][8*i +: 8] <= ex_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             req_valid;
    int               sel;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [3:0]       req_be;
    logic             rsp_ready;

    logic [2:0]       vsel;
    logic [2:0]       rdy;
    logic [2:0]       vld;
    logic [2:0]       err;
    logic [2:0][31:0] rd;

    int n_vec = 0;
    int n_err = 0;

    assign vsel[0] = req_valid && (sel == 0);
    assign vsel[1] = req_valid && (sel == 1);
    assign vsel[2] = req_valid && (sel == 2);

    // instance 0: no wait states, 1: three, 2: four
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .rst(rst), .req_valid(vsel[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(err[0])
    );
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) u_d3 (
        .clk(clk), .rst(rst), .req_valid(vsel[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(err[1])
    );
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(4)) u_d4 (
        .clk(clk), .rst(rst), .req_valid(vsel[2]), .req_ready(rdy[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(err[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present a request and wait until instance s accepts it. Leaves the
    // clock #1 after the accept edge with the request inputs scrambled.
    task automatic issue(input int s, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        int n;
        sel       = s;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        n = 0;
        #1;
        while (!rdy[s] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h0000_0004;
        req_wdata = ~wd;
        req_be    = 4'hF;
    endtask

    // Full transaction: latency, response value and error, optional
    // backpressure for 'stall' cycles, then return to idle.
    task automatic txn(input string tag, input int s, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input int stall, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err);
        int   lat;
        logic rdy_seen;
        rsp_ready = (stall == 0);
        issue(s, we, a, wd, be);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!vld[s] && lat < 40) begin
            if (rdy[s]) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (rdy[s]) rdy_seen = 1'b1;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rd[s], exp_rd);
        chk({tag, "_err"}, {31'h0, err[s]}, {31'h0, exp_err});
        chk({tag, "_busy"}, {31'h0, rdy_seen}, 32'h0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_v"}, {30'h0, vld[s], rdy[s]}, 32'h2);
            chk({tag, "_stall_d"}, rd[s], exp_rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'h0, vld[s], rdy[s]}, 32'h1);
        chk({tag, "_clr"}, {err[s], rd[s][30:0]} | {31'h0, rd[s][31]}, 32'h0);
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        req_valid = 1'b0;
        sel       = 0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_ready", {29'h0, rdy}, 32'h7);
        chk("rst_valid", {29'h0, vld}, 32'h0);
        chk("rst_err", {29'h0, err}, 32'h0);
        chk("rst_rdata", rd[0] | rd[1] | rd[2], 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // no wait states: full store, load back, partial store, be=0 store
        txn("st_full", 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0, 1'b0);
        txn("ld_full", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, 1'b0);
        txn("st_part", 0, 1'b1, 32'h10, 32'h0000_1234, 4'h3, 0, 1, 32'h0, 1'b0);
        txn("ld_part", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1, 32'hDEAD_1234, 1'b0);
        txn("st_be0", 0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 1, 32'h0, 1'b0);
        txn("ld_be0", 0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1, 32'hDEAD_1234, 1'b0);

        // three wait states
        txn("ld_w3", 1, 1'b0, 32'h0, 32'h0, 4'hF, 0, 4, 32'h0, 1'b0);

        // error cases and the last legal word
        txn("ld_mis", 0, 1'b0, 32'h12, 32'h0, 4'hF, 0, 1, 32'h0, 1'b1);
        txn("st_oor", 0, 1'b1, 32'h400, 32'hA5A5_A5A5, 4'hF, 0, 1, 32'h0, 1'b1);
        txn("ld_nowrap", 0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 1'b0);
        txn("ld_last", 0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 1, 32'h0, 1'b0);
        txn("st_last", 0, 1'b1, 32'h3FC, 32'h1122_3344, 4'hC, 0, 1, 32'h0, 1'b0);
        txn("ld_last2", 0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 1, 32'h1122_0000, 1'b0);

        // backpressure on a pending load
        txn("ld_bp", 0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1, 32'hDEAD_1234, 1'b0);
        txn("ld_bp_w3", 1, 1'b0, 32'h3FC, 32'h0, 4'h0, 2, 4, 32'h0, 1'b0);

        // reset during wait states drops the store
        rsp_ready = 1'b1;
        issue(2, 1'b1, 32'h20, 32'h55, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstw_ready", {31'h0, rdy[2]}, 32'h1);
        chk("rstw_valid", {31'h0, vld[2]}, 32'h0);
        chk("rstw_out", {err[2], rd[2][30:0]} | {31'h0, rd[2][31]}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        txn("ld_rstw", 2, 1'b0, 32'h20, 32'h0, 4'h0, 0, 5, 32'h0, 1'b0);

        // reset while holding the response keeps the committed store
        rsp_ready = 1'b0;
        issue(0, 1'b1, 32'h24, 32'h77, 4'hF);
        n = 0;
        while (!vld[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstr_inresp", {31'h0, vld[0]}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstr_valid", {30'h0, vld[0], rdy[0]}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        txn("ld_rstr", 0, 1'b0, 32'h24, 32'h0, 4'h0, 0, 1, 32'h77, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
